// File: rtl/iob_uart16550_tb_driver.sv
// IOb master that configures a UART16550 and then shuttles bytes between its
// RBR/THR and simple byte streams. Optional timeout: IOB_UART_TB_DRIVER_TIMEOUT_EN.
module iob_uart16550_tb_driver #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 32,
    parameter logic [15:0] BAUD_DIV = 16'd1,
    parameter int          POLL_GAP = 4,
    parameter int          TIMEOUT  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              iob_avalid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    output logic [DATA_W-1:0] iob_wdata_o,
    output logic [3:0]        iob_wstrb_o,
    input  logic [DATA_W-1:0] iob_rdata_i,
    input  logic              iob_ready_i,
    input  logic              iob_rvalid_i,
    output logic              init_done_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              error_o
);

    typedef enum logic [2:0] {
        S_CFG, S_LSR_REQ, S_LSR_WAIT, S_RBR_REQ, S_RBR_WAIT, S_THR_REQ, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic              avalid_q, avalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              init_done_q, init_done_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              prio_tx_q, prio_tx_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [15:0]       gap_q, gap_d;
`ifdef IOB_UART_TB_DRIVER_TIMEOUT_EN
    logic [15:0]       to_q, to_d;
    logic              error_q, error_d;
    logic              waiting;
`endif

    logic       hs;
    logic [7:0] rd_byte;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_byte;
    logic       rx_cand, tx_cand, serve_rx, serve_tx;
    state_t     post_dst;

    always_comb begin
        case (step_q)
            3'd0:    begin cfg_addr = 3'd3; cfg_byte = 8'h83;           end
            3'd1:    begin cfg_addr = 3'd0; cfg_byte = BAUD_DIV[7:0];   end
            3'd2:    begin cfg_addr = 3'd1; cfg_byte = BAUD_DIV[15:8];  end
            3'd3:    begin cfg_addr = 3'd3; cfg_byte = 8'h03;           end
            default: begin cfg_addr = 3'd2; cfg_byte = 8'h07;           end
        endcase
    end

    assign hs       = avalid_q & iob_ready_i;
    assign rd_byte  = iob_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign rx_cand  = rd_byte[0] & ~rx_valid_q;
    assign tx_cand  = rd_byte[5] & tx_valid_i;
    assign serve_rx = rx_cand & (~tx_cand | ~prio_tx_q);
    assign serve_tx = tx_cand & ~serve_rx;
    assign post_dst = (POLL_GAP == 0) ? S_LSR_REQ : S_GAP;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        avalid_d    = avalid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        init_done_d = init_done_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        prio_tx_d   = prio_tx_q;
        tx_byte_d   = tx_byte_q;
        gap_d       = gap_q;
        tx_ready_o  = 1'b0;

        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

        // Request states raise avalid one cycle after entry; handshake drops it.
        case (state_q)
            S_CFG: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = ADDR_W'(cfg_addr);
                    wdata_d  = {(DATA_W/8){cfg_byte}};
                    wstrb_d  = 4'b0001 << cfg_addr[1:0];
                end else if (hs) begin
                    avalid_d = 1'b0;
                    if (step_q == 3'd4) begin
                        init_done_d = 1'b1;
                        state_d     = S_LSR_REQ;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_LSR_REQ, S_RBR_REQ: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = (state_q == S_LSR_REQ) ? ADDR_W'(5) : '0;
                    wstrb_d  = '0;
                end else if (hs) begin
                    avalid_d = 1'b0;
                    if (!iob_rvalid_i)
                        state_d = (state_q == S_LSR_REQ) ? S_LSR_WAIT : S_RBR_WAIT;
                end
            end
            default: ;
        endcase

        // Read data may arrive with the handshake or later in the wait state.
        if (iob_rvalid_i && ((state_q == S_LSR_WAIT) || (state_q == S_LSR_REQ && hs))) begin
            if (rx_cand && tx_cand) prio_tx_d = ~prio_tx_q;
            if (serve_rx) begin
                state_d = S_RBR_REQ;
            end else if (serve_tx) begin
                state_d   = S_THR_REQ;
                tx_byte_d = tx_data_i;
            end else begin
                state_d = post_dst;
                gap_d   = '0;
            end
        end

        if (iob_rvalid_i && ((state_q == S_RBR_WAIT) || (state_q == S_RBR_REQ && hs))) begin
            rx_data_d  = rd_byte;
            rx_valid_d = 1'b1;
            state_d    = post_dst;
            gap_d      = '0;
        end

        if (state_q == S_THR_REQ) begin
            if (!avalid_q) begin
                avalid_d = 1'b1;
                addr_d   = '0;
                wdata_d  = {(DATA_W/8){tx_byte_q}};
                wstrb_d  = 4'b0001;
            end else if (hs) begin
                avalid_d   = 1'b0;
                tx_ready_o = 1'b1;
                state_d    = post_dst;
                gap_d      = '0;
            end
        end

        if (state_q == S_GAP) begin
            if (gap_q == 16'(POLL_GAP - 1)) state_d = S_LSR_REQ;
            else                            gap_d   = gap_q + 16'd1;
        end

`ifdef IOB_UART_TB_DRIVER_TIMEOUT_EN
        error_d = error_q;
        waiting = (avalid_q & ~iob_ready_i) |
                  (((state_q == S_LSR_WAIT) || (state_q == S_RBR_WAIT)) & ~iob_rvalid_i);
        to_d    = waiting ? to_q + 16'd1 : '0;
        if (waiting && (to_q == 16'(TIMEOUT - 1))) begin
            error_d  = 1'b1;
            avalid_d = 1'b0;
            to_d     = '0;
            gap_d    = '0;
            state_d  = init_done_q ? post_dst : S_CFG;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_CFG;
            step_q      <= '0;
            avalid_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            init_done_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            prio_tx_q   <= 1'b0;
            tx_byte_q   <= '0;
            gap_q       <= '0;
`ifdef IOB_UART_TB_DRIVER_TIMEOUT_EN
            to_q        <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            avalid_q    <= avalid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            init_done_q <= init_done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            prio_tx_q   <= prio_tx_d;
            tx_byte_q   <= tx_byte_d;
            gap_q       <= gap_d;
`ifdef IOB_UART_TB_DRIVER_TIMEOUT_EN
            to_q        <= to_d;
            error_q     <= error_d;
`endif
        end
    end

    assign iob_avalid_o = avalid_q;
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = wdata_q;
    assign iob_wstrb_o  = wstrb_q;
    assign init_done_o  = init_done_q;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
`ifdef IOB_UART_TB_DRIVER_TIMEOUT_EN
    assign error_o      = error_q;
`else
    assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_iob_uart16550_tb_driver.sv
// Bench for iob_uart16550_tb_driver: behavioural UART register slave, byte
// producer/consumer and a serve-order model driven by randomized traffic.
module tb_iob_uart16550_tb_driver;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        iob_avalid_o;
    logic [15:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic [31:0] iob_rdata_i = '0;
    logic        iob_ready_i = 1'b0;
    logic        iob_rvalid_i = 1'b0;
    logic        init_done_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic [7:0]  tx_data_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic        error_o;

    always #5 clk = ~clk;

    iob_uart16550_tb_driver #(
        .ADDR_W(16), .DATA_W(32), .BAUD_DIV(16'h0010), .POLL_GAP(2), .TIMEOUT(8)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
        .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
        .iob_rdata_i(iob_rdata_i), .iob_ready_i(iob_ready_i),
        .iob_rvalid_i(iob_rvalid_i), .init_done_o(init_done_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .error_o(error_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // knobs set by the directed sequence
    int stall_max = 0, rv_max = 0, fix_stall = 0, fix_rv = 0;
    bit fixed_delays = 0, slave_dead = 0, rx_hold = 0;
    int thre_pct = 0, rxrdy_pct = 100;

    // slave / stream model state
    logic [7:0] uart_fifo[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];
    int  exp_cfg_addr[5] = '{3, 0, 1, 3, 2};
    int  exp_cfg_data[5] = '{8'h83, 8'h10, 8'h00, 8'h03, 8'h07};
    int  cfg_cnt = 0, rbr_reads = 0, rx_got = 0, tx_sent = 0;
    bit  seen = 0, rd_pending = 0, rd_is_lsr = 0, lsr_resp = 0, lsr_dr = 0, lsr_thre = 0;
    bit  thr_hs = 0, prio_model = 0;
    int  stall_left = 0, rd_cnt = 0, exp_act = 0, act = 0;
    logic [15:0] h_addr;
    logic [31:0] h_wdata, rd_word;
    logic [3:0]  h_wstrb;
    logic [7:0]  thr_byte, lsr, wbyte;

    task automatic set_rst(input logic v);
        @(posedge clk);
        #2 rst_n_i = v;
    endtask

    initial forever begin
        @(negedge clk);
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        thr_hs       = 0;
        act          = 0;
        if (!rst_n_i) begin
            seen = 0; rd_pending = 0; lsr_resp = 0; cfg_cnt = 0;
            prio_model = 0; exp_act = 0; exp_rx.delete();
            rx_ready_i = 1'b0;
            continue;
        end
        if (rd_pending) begin
            if (rd_cnt == 0) begin
                iob_rvalid_i = 1'b1; iob_rdata_i = rd_word;
                rd_pending = 0; lsr_resp = rd_is_lsr;
            end else rd_cnt--;
        end else if (iob_avalid_o && !slave_dead) begin
            if (!seen) begin
                seen = 1; h_addr = iob_addr_o; h_wdata = iob_wdata_o; h_wstrb = iob_wstrb_o;
                stall_left = fixed_delays ? fix_stall : $urandom_range(stall_max);
            end else begin
                chk("stable_addr", iob_addr_o, h_addr);
                chk("stable_wdata", iob_wdata_o, h_wdata);
                chk("stable_wstrb", iob_wstrb_o, h_wstrb);
            end
            if (stall_left > 0) stall_left--;
            else begin
                iob_ready_i = 1'b1;
                seen = 0;
                if (h_wstrb != 4'b0) begin
                    wbyte = h_wdata[8*h_addr[1:0] +: 8];
                    chk("wstrb_lane", h_wstrb, 4'b0001 << h_addr[1:0]);
                    if (cfg_cnt < 5) begin
                        chk("cfg_addr", h_addr, exp_cfg_addr[cfg_cnt]);
                        chk("cfg_data", wbyte, exp_cfg_data[cfg_cnt]);
                        cfg_cnt++;
                    end else begin
                        chk("thr_addr", h_addr, 0);
                        thr_hs = 1; thr_byte = wbyte; act = 2;
                    end
                end else begin
                    if (cfg_cnt < 5) chk("read_in_cfg", 1, 0);
                    rd_word = $urandom;
                    if (h_addr == 16'd5) begin
                        lsr_dr   = (uart_fifo.size() > 0);
                        lsr_thre = ($urandom_range(99) < thre_pct);
                        lsr = ($urandom & 8'hDE) | {2'b0, lsr_thre, 4'b0, lsr_dr};
                        rd_word[15:8] = lsr; rd_is_lsr = 1; act = 3;
                    end else begin
                        chk("read_addr", h_addr, 0);
                        chk("rbr_buf_empty", rx_valid_o, 0);
                        chk("rbr_fifo_nonempty", uart_fifo.size() > 0, 1);
                        rd_word[7:0] = (uart_fifo.size() > 0) ? uart_fifo.pop_front() : 8'h00;
                        exp_rx.push_back(rd_word[7:0]);
                        rbr_reads++; rd_is_lsr = 0; act = 1;
                    end
                    rd_cnt = fixed_delays ? fix_rv : $urandom_range(rv_max);
                    if (rd_cnt == 0) begin
                        iob_rvalid_i = 1'b1; iob_rdata_i = rd_word; lsr_resp = rd_is_lsr;
                    end else begin
                        rd_pending = 1; rd_cnt--;
                    end
                end
                if (exp_act != 0 && act != 0) begin
                    chk("serve_order", act, exp_act);
                    exp_act = 0;
                end
            end
        end
        // byte consumer
        rx_ready_i = rx_hold ? 1'b0 : ($urandom_range(99) < rxrdy_pct);
        if (rx_valid_o && rx_ready_i) begin
            if (exp_rx.size() == 0) chk("rx_spurious", 1, 0);
            else chk("rx_byte", rx_data_o, exp_rx.pop_front());
            rx_got++;
        end
        #1;
        // byte producer
        if (thr_hs || tx_ready_o) chk("tx_ready_pulse", tx_ready_o, thr_hs);
        if (thr_hs) begin
            chk("thr_data", thr_byte, tx_data_i);
            tx_sent++;
            tx_valid_i = 1'b0;
        end
        if (!tx_valid_i && tx_src.size() > 0) begin
            tx_data_i = tx_src.pop_front(); tx_valid_i = 1'b1;
        end
        // serve decision implied by the LSR value just returned
        if (lsr_resp) begin
            if (lsr_dr && !rx_valid_o && lsr_thre && tx_valid_i) begin
                exp_act = prio_model ? 2 : 1;
                prio_model = ~prio_model;
            end else if (lsr_dr && !rx_valid_o) exp_act = 1;
            else if (lsr_thre && tx_valid_i)   exp_act = 2;
            else                                exp_act = 3;
            lsr_resp = 0;
        end
    end

    int base, rx_tgt, tx_tgt, cnt;

    initial begin
        // reset state
        set_rst(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_avalid", iob_avalid_o, 0);
        chk("rst_addr", iob_addr_o, 0);
        chk("rst_wdata", iob_wdata_o, 0);
        chk("rst_wstrb", iob_wstrb_o, 0);
        chk("rst_init_done", init_done_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_rx_data", rx_data_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_error", error_o, 0);
        set_rst(1'b1);

        // init sequence, zero-wait slave
        for (int i = 0; i < 200 && !init_done_o; i++) @(negedge clk);
        chk("init_done", init_done_o, 1);
        chk("cfg_count", cfg_cnt, 5);

        // receive only
        rxrdy_pct = 100; thre_pct = 0;
        for (int i = 0; i < 8; i++) uart_fifo.push_back(8'($urandom));
        rx_tgt = rx_got + 8;
        for (int i = 0; i < 3000 && rx_got < rx_tgt; i++) @(negedge clk);
        chk("rx_basic_count", rx_got, rx_tgt);
        base = rbr_reads;
        repeat (50) @(negedge clk);
        chk("no_rbr_when_empty", rbr_reads - base, 0);

        // consumer stalled: one byte buffered, rest stays in the UART
        rx_hold = 1;
        base = rbr_reads;
        for (int i = 0; i < 4; i++) uart_fifo.push_back(8'($urandom));
        repeat (100) @(negedge clk);
        chk("hold_rx_valid", rx_valid_o, 1);
        chk("hold_one_read", rbr_reads - base, 1);
        chk("hold_rx_data", rx_data_o, exp_rx[0]);
        rx_hold = 0;
        rx_tgt = rx_got + 4;
        for (int i = 0; i < 3000 && rx_got < rx_tgt; i++) @(negedge clk);
        chk("hold_drain_count", rx_got, rx_tgt);

        // both directions ready every poll: alternation
        thre_pct = 100;
        for (int i = 0; i < 6; i++) begin
            uart_fifo.push_back(8'($urandom)); tx_src.push_back(8'($urandom));
        end
        rx_tgt = rx_got + 6; tx_tgt = tx_sent + 6;
        for (int i = 0; i < 4000 && (rx_got < rx_tgt || tx_sent < tx_tgt); i++) @(negedge clk);
        chk("alt_rx_count", rx_got, rx_tgt);
        chk("alt_tx_count", tx_sent, tx_tgt);

        // fixed stalls: ready after 3 cycles, rvalid 2 cycles after ready
        fixed_delays = 1; fix_stall = 3; fix_rv = 2; thre_pct = 50;
        for (int i = 0; i < 5; i++) begin
            uart_fifo.push_back(8'($urandom)); tx_src.push_back(8'($urandom));
        end
        rx_tgt = rx_got + 5; tx_tgt = tx_sent + 5;
        for (int i = 0; i < 6000 && (rx_got < rx_tgt || tx_sent < tx_tgt); i++) @(negedge clk);
        chk("stall_rx_count", rx_got, rx_tgt);
        chk("stall_tx_count", tx_sent, tx_tgt);

        // random mix
        fixed_delays = 0; stall_max = 3; rv_max = 2; rxrdy_pct = 60; thre_pct = 70;
        for (int i = 0; i < 20; i++) begin
            uart_fifo.push_back(8'($urandom)); tx_src.push_back(8'($urandom));
        end
        rx_tgt = rx_got + 20; tx_tgt = tx_sent + 20;
        for (int i = 0; i < 20000 && (rx_got < rx_tgt || tx_sent < tx_tgt); i++) @(negedge clk);
        chk("rand_rx_count", rx_got, rx_tgt);
        chk("rand_tx_count", tx_sent, tx_tgt);
        chk("no_error", error_o, 0);

`ifdef IOB_UART_TB_DRIVER_TIMEOUT_EN
        // dead slave: timeout after 8 waiting cycles, then reset recovery
        slave_dead = 1;
        set_rst(1'b0);
        repeat (2) @(posedge clk);
        set_rst(1'b1);
        for (int i = 0; i < 20 && !iob_avalid_o; i++) @(negedge clk);
        chk("to_avalid_rise", iob_avalid_o, 1);
        for (cnt = 0; cnt < 20 && !error_o; cnt++) @(negedge clk);
        chk("to_cycles", cnt, 8);
        chk("to_avalid_drop", iob_avalid_o, 0);
        chk("to_no_init", init_done_o, 0);
        repeat (20) @(negedge clk);
        chk("to_sticky", error_o, 1);
        set_rst(1'b0);
        slave_dead = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("to_rst_clear", error_o, 0);
        set_rst(1'b1);
        for (int i = 0; i < 200 && !init_done_o; i++) @(negedge clk);
        chk("to_reinit_done", init_done_o, 1);
        chk("to_reinit_cfg", cfg_cnt, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
